// File: rtl/memwb_pkg.sv
// Shared MEM/WB definitions: data-path width default and the write-back control bundle
// reused by every pipeline stage register.
package memwb_pkg;

  localparam int unsigned ARQ_DEFAULT = 16;

  typedef struct packed {
    logic mem_rd_mux;  // 1 = memory data, 0 = ALU result
    logic wb_enable;   // register-file write enable
  } memwb_ctrl_t;

  localparam int unsigned CTRL_W = $bits(memwb_ctrl_t);

endpackage : memwb_pkg

// File: rtl/memwb_pipe_if.sv
// One side of the MEM/WB boundary: control bundle plus both candidate results.
// The master drives a stage's contents, the slave consumes them.
interface memwb_pipe_if
  import memwb_pkg::*;
#(
  parameter int unsigned ARQ = ARQ_DEFAULT
);

  logic           mem_rd_mux;
  logic           wb_enable;
  logic [ARQ-1:0] alu_result;
  logic [ARQ-1:0] mem_result;

  modport master (
    output mem_rd_mux,
    output wb_enable,
    output alu_result,
    output mem_result
  );

  modport slave (
    input mem_rd_mux,
    input wb_enable,
    input alu_result,
    input mem_result
  );

endinterface : memwb_pipe_if

// File: rtl/memwb_pipe_pipe_reg.sv
// Generic pipeline stage register: sync active-high reset, flush loads a bubble (all zero),
// stall holds. Flush outranks stall.
module pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule : pipe_reg

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register: captures the write-back control bits and both result buses,
// presenting them to the WB stage one cycle later. All outputs come straight from flops.
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int unsigned ARQ = ARQ_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_rd_mux_in,
  input  logic           wb_enable_in,
  input  logic [ARQ-1:0] alu_result_in,
  input  logic [ARQ-1:0] mem_result_in,
  output logic           mem_rd_mux_out,
  output logic           wb_enable_out,
  output logic [ARQ-1:0] alu_result_out,
  output logic [ARQ-1:0] mem_result_out,
  input  logic           stall = 1'b0,
  input  logic           flush = 1'b0
);

  localparam int unsigned W = CTRL_W + 2 * ARQ;

  memwb_ctrl_t  ctrl_d;
  memwb_ctrl_t  ctrl_q;
  logic [W-1:0] stage_d;
  logic [W-1:0] stage_q;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.mem_rd_mux = mem_rd_mux_in;
    ctrl_d.wb_enable  = wb_enable_in;
    stage_d           = {ctrl_d, alu_result_in, mem_result_in};
  end

  pipe_reg #(
    .WIDTH(W)
  ) u_stage (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .stall (stall),
    .d     (stage_d),
    .q     (stage_q)
  );

  always_comb begin
    {ctrl_q, alu_result_out, mem_result_out} = stage_q;
    mem_rd_mux_out = ctrl_q.mem_rd_mux;
    wb_enable_out  = ctrl_q.wb_enable;
  end

endmodule : memwb_pipe

// File: tb/tb_memwb_pipe.sv
// Scoreboard bench for memwb_pipe: stimulus pushes the expected stage contents per edge,
// a negedge monitor pops and compares against the DUT outputs.
module tb_memwb_pipe;
  import memwb_pkg::*;

  localparam int unsigned ARQ = ARQ_DEFAULT;

  typedef struct {
    logic           mr;
    logic           we;
    logic [ARQ-1:0] alu;
    logic [ARQ-1:0] mem;
    string          tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;

  memwb_pipe_if #(.ARQ(ARQ)) st_in ();
  memwb_pipe_if #(.ARQ(ARQ)) st_out ();

  memwb_pipe #(
    .ARQ(ARQ)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_mux_in  (st_in.mem_rd_mux),
    .wb_enable_in   (st_in.wb_enable),
    .alu_result_in  (st_in.alu_result),
    .mem_result_in  (st_in.mem_result),
    .mem_rd_mux_out (st_out.mem_rd_mux),
    .wb_enable_out  (st_out.wb_enable),
    .alu_result_out (st_out.alu_result),
    .mem_result_out (st_out.mem_result),
    .stall          (stall),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t model;
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input string tag,
                     input logic [ARQ-1:0] act, input logic [ARQ-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s: got %h required %h at %0t", tag, name, act, req, $time);
    end
  endtask

  // Reference: the stage holds the last accepted transaction; reset or flush empties it.
  task automatic step(input string tag, input logic r, input logic f, input logic s,
                      input logic mr, input logic we,
                      input logic [ARQ-1:0] a, input logic [ARQ-1:0] m);
    rst   = r;
    flush = f;
    stall = s;
    st_in.mem_rd_mux = mr;
    st_in.wb_enable  = we;
    st_in.alu_result = a;
    st_in.mem_result = m;
    if (r || f) begin
      model.mr  = 1'b0;
      model.we  = 1'b0;
      model.alu = '0;
      model.mem = '0;
    end else if (!s) begin
      model.mr  = mr;
      model.we  = we;
      model.alu = a;
      model.mem = m;
    end
    model.tag = tag;
    q.push_back(model);
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("mem_rd_mux", mon_e.tag, ARQ'(st_out.mem_rd_mux), ARQ'(mon_e.mr));
        chk("wb_enable",  mon_e.tag, ARQ'(st_out.wb_enable),  ARQ'(mon_e.we));
        chk("alu_result", mon_e.tag, st_out.alu_result, mon_e.alu);
        chk("mem_result", mon_e.tag, st_out.mem_result, mon_e.mem);
      end
    end
  end

  initial begin
    logic [ARQ-1:0] ra;
    logic [ARQ-1:0] rm;
    logic [ARQ-1:0] pa [3];
    logic [ARQ-1:0] pm [3];

    pa[0] = 16'h0001; pm[0] = 16'hFFFF;
    pa[1] = 16'h8000; pm[1] = 16'h7FFF;
    pa[2] = 16'hAAAA; pm[2] = 16'h5555;

    for (int i = 0; i < 10; i++) begin
      ra = ARQ'($urandom());
      rm = ARQ'($urandom());
      step("reset", 1'b1, 1'b0, 1'($urandom()), 1'($urandom()), 1'($urandom()), ra, rm);
    end

    step("load", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0456, 16'h0752);
    step("load_hold", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0456, 16'h0752);
    step("rst_mid", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0456, 16'h0752);
    step("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0F0F, 16'hF0F0);

    for (int i = 0; i < 3; i++) begin
      step("stream", 1'b0, 1'b0, 1'b0, 1'($urandom()), 1'($urandom()), pa[i], pm[i]);
    end

    step("ld_1234", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'hABCD);
    for (int i = 0; i < 3; i++) begin
      ra = ARQ'($urandom());
      rm = ARQ'($urandom());
      step("stall", 1'b0, 1'b0, 1'b1, 1'($urandom()), 1'b1, ra, rm);
    end
    step("flush_stall", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222);
    step("post_flush", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h3333, 16'h4444);

    for (int i = 0; i < 300; i++) begin
      ra = ARQ'($urandom());
      rm = ARQ'($urandom());
      step("random", $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, 1'($urandom()), 1'($urandom()), ra, rm);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_memwb_pipe

// File: doc/memwb_pipe.md
# memwb_pipe

Pipeline register between the MEM and WB stages of the 16-bit processor datapath. It captures the write-back control bits (result-select mux and register-file write enable) and both candidate results (ALU result, memory read data) on each rising clock edge and presents them to the write-back stage one cycle later. Optional stall and flush inputs let the hazard unit freeze the stage or inject a bubble.

## Interface
Parameters:
- ARQ, 16, data-path width in bits for both result buses.

Ports, in positional order; stall and flush are appended last with default 0 so 10-port positional instantiations remain valid:
- clk  input  1  rising-edge clock; one clock, no other clock domains.
- rst  input  1  reset; synchronous and active-high.
- mem_rd_mux_in  input  1  WB result select from MEM stage (1 = memory data, 0 = ALU result).
- wb_enable_in  input  1  register-file write enable from MEM stage.
- alu_result_in  input  ARQ  ALU result carried through MEM.
- mem_result_in  input  ARQ  data-memory read result.
- mem_rd_mux_out  output  1  registered mem_rd_mux_in.
- wb_enable_out  output  1  registered wb_enable_in.
- alu_result_out  output  ARQ  registered alu_result_in.
- mem_result_out  output  ARQ  registered mem_result_in.
- stall  input  1  default 0; hold the current contents.
- flush  input  1  default 0; load a bubble.

## Operation
- All four outputs come directly from flops; no combinational path from any input to any output.
- Per rising edge, priority order:
  - rst = 1: all outputs load 0.
  - Else flush = 1: all outputs load 0. The resulting bubble has wb_enable_out = 0.
  - Else stall = 1: all outputs keep their current values.
  - Else: each output loads its matching _in value.
- flush takes precedence over stall when both are asserted.
- Data is passed through unmodified at full ARQ width: no sign extension, truncation or arithmetic.
- The result mux itself lives in the WB stage, not in this block.

## Timing
- Latency is 1 cycle: a value present at posedge N appears on the outputs after posedge N and stays until the next enabled edge.
- Reset is sampled only on clock edges:
  - Asserting rst mid-operation clears the outputs at the next posedge, not immediately.
  - Deasserting rst allows a load on the first posedge at which rst is sampled low.
- Values before the first clock edge are undefined. The bench must not check outputs before the first reset edge.
- Throughput is 1 transfer per cycle when stall = 0.

## Structure
- Shared package memwb_pkg holds:
  - localparam ARQ_DEFAULT = 16.
  - Packed struct memwb_ctrl_t {mem_rd_mux, wb_enable}, so IF/ID, ID/EX and EX/MEM stages reuse the control bundle.
- One sub-module, pipe_reg, is natural:
  - Generic WIDTH-bit register with sync active-high rst, flush (clear) and stall (hold).
  - memwb_pipe instantiates it for the packed concatenation {ctrl, alu_result, mem_result}, width 2 + 2·ARQ.
- Other pipeline stage registers reuse pipe_reg.

## Test plan
Clock period is 10 ns.
- Reset: rst = 1 for 10 cycles with arbitrary inputs -> all outputs 0 after the first posedge and remain 0.
- Load: rst = 0, mem_rd_mux_in = 1, wb_enable_in = 0, alu_result_in = 1110 (0x0456), mem_result_in = 1874 (0x0752) -> after the next posedge the outputs are 1, 0, 0x0456, 0x0752. Nothing changes between edges.
- Reset mid-operation: with the loaded values above, assert rst between edges -> the outputs hold until the next posedge, then all are 0.
- Streaming: drive a new pair of alu/mem values every cycle (0x0001/0xFFFF, 0x8000/0x7FFF, 0xAAAA/0x5555) -> each pair appears exactly 1 cycle later, with all bits preserved.
- Stall/flush: load 0x1234/0xABCD with wb_enable_in = 1.
  - Hold stall = 1 for 3 cycles while the inputs change -> the outputs stay 0x1234/0xABCD/1.
  - Then assert flush = 1 together with stall = 1 -> the outputs become 0, including wb_enable_out = 0.
